rd_fwft_stage: RTL
==================

Name: rd_fwft_stage

Overview:
- Read-side output stage of the async FIFO, in the read clock domain, directly downstream of the read pointer handler and the dual-port RAM read port.
- Drives the handler's read request and captures RAM read data, which returns one cycle after an accepted read.
- Presents a first-word-fall-through valid/ready stream to the consumer through a small registered prefetch buffer.
- Hides RAM read latency so a ready consumer sees one word per cycle.

Parameters:
- DSIZE, 8, data word width in bits.
- BUF_DEPTH, 3, prefetch buffer entries; legal range 2..8; 3 is the minimum for full throughput.
- CNT_W, 2, width of out_count; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- rdclk  input  1  read-domain clock; all state on rising edge.
- in_resetn  input  1  synchronous active-low reset, sampled on rdclk.
- in_fifo_empty  input  1  empty flag from the read pointer handler.
- in_ram_rdata  input  DSIZE  RAM read data; valid the cycle after an accepted read.
- out_rd_req  output  1  read request to the handler's read-enable input.
- in_ready  input  1  consumer ready.
- out_valid  output  1  buffer head holds a word.
- out_data  output  DSIZE  buffer head word.
- out_count  output  CNT_W  words currently held in the buffer.

Behaviour:
- Reset (in_resetn low at a rising edge):
  - occupancy 0, in-flight flag 0, head/tail pointers 0.
  - out_valid=0, out_rd_req=0, out_count=0; out_data is don't-care, but storage is cleared to 0.
- rd_fire = out_rd_req && !in_fifo_empty. This is the same gating the handler applies, so rd_fire equals an actual RAM read.
- out_rd_req = !in_fifo_empty && (occupancy + inflight) < BUF_DEPTH.
  - Purely from registered state plus in_fifo_empty.
  - No combinational path from in_ready.
- inflight register <= rd_fire; at most one read outstanding per cycle of latency.
- Capture: when inflight=1, write in_ram_rdata at the tail and advance the tail.
  - Credit accounting guarantees space, so no overflow is possible.
- Pop: pop = out_valid && in_ready; advance the head.
- out_valid = occupancy != 0. out_data = mem[head]; registered storage, a mux of flops.
- occupancy next = occupancy + inflight - pop. Capture and pop in the same cycle leave occupancy unchanged.
- Empty-buffer capture: the word becomes visible on out_valid the cycle after capture (registered).
  - First-word latency from in_fifo_empty falling: read request in cycle 0, data captured at end of cycle 1, out_valid in cycle 2.
- Pointer wrap:
  - Head and tail wrap from BUF_DEPTH-1 to 0.
  - When BUF_DEPTH is not a power of two, wrap by explicit compare, not by truncation.
- out_count = occupancy.
- Consumer stall: reads stop once occupancy + inflight reaches BUF_DEPTH. The in-flight word still lands.
- in_fifo_empty rising while a read is in flight: the in-flight word is still captured (the read was already accepted).
- Reset asserted mid-transfer: the in-flight word is discarded, all state clears, no pop is reported.
- out_valid must stay high and out_data stable while in_ready=0 (AXI-style valid hold).

Decomposition:
- Shared package: DSIZE default, and a function clog2-style helper for pointer width.
- No typedefs are needed; the block has no FSM beyond the occupancy counter and in-flight flag.
- One natural sub-module, fwft_buf_mem: the BUF_DEPTH x DSIZE register array with head/tail pointers, write and pop strobes, and read mux.
- Credit logic and the in-flight flag stay in the parent.

Test Plan:
- Reset then idle, in_fifo_empty=1 -> out_valid=0, out_rd_req=0, out_count=0 for 10 cycles.
- Single word: in_fifo_empty low for 1 cycle, RAM returns 0xA5 -> out_rd_req=1 in cycle 0, out_valid=1 with out_data=0xA5 from cycle 2; in_ready=1 then gives out_valid=0 the next cycle.
- Streaming with BUF_DEPTH=3: FIFO holds 0x01..0x10, in_ready=1 throughout -> after a 2-cycle fill, 16 consecutive pops, one per cycle, in order.
- Backpressure: in_ready=0 with a non-empty FIFO -> out_count settles at 3, out_rd_req=0, out_data=first word held stable; releasing in_ready drains 3 words in order and reads resume.
- Empty during flight: in_fifo_empty rises the cycle after an accepted read -> that word (0x5C) is still captured and out_count=1; no further reads.
- Reset mid-operation: in_resetn low with out_count=2 and inflight=1 -> next cycle out_valid=0, out_count=0, out_rd_req=0; the stale in_ram_rdata is not captured.

Source files
------------

// File: rtl/rd_fwft_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rd_fwft_stage_pkg
// Description : Shared defaults and helpers for the async-FIFO read-side
//               first-word-fall-through output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_fwft_stage_pkg;

    localparam int DSIZE_DEFAULT = 8;

    // Pointer width able to address DEPTH entries; never narrower than 1 bit.
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : rd_fwft_stage_pkg
`default_nettype wire

// File: rtl/fwft_buf_mem.sv
`default_nettype none
// ============================================================================
// Module      : fwft_buf_mem
// Description : DEPTH x DSIZE flop array used as a circular prefetch buffer.
//               Words are written at the tail, read combinationally from the
//               head, and the head advances on a pop.
// Ports       : clk        - clock, all state on rising edge
//               resetn     - synchronous active-low reset
//               i_wr_en    - write i_wr_data at tail, advance tail
//               i_wr_data  - word to store
//               i_pop      - advance head
//               o_rd_data  - word at head (mux of flops)
// Revision    : 1.0 - initial release
// ============================================================================
module fwft_buf_mem #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 3,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_wr_en,
    input  logic [DSIZE-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [DSIZE-1:0] o_rd_data
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    // Explicit wrap compare so non-power-of-two depths stay in range.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (i_pop) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
        end
        if (i_wr_en) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (i_wr_en) begin
                mem_q[tail_q] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = mem_q[head_q];

endmodule : fwft_buf_mem
`default_nettype wire

// File: rtl/rd_fwft_stage.sv
`default_nettype none
// ============================================================================
// Module      : rd_fwft_stage
// Description : Read-side output stage of the async FIFO. Issues reads to the
//               read pointer handler, captures RAM data one cycle later into a
//               small prefetch buffer and presents a first-word-fall-through
//               valid/ready stream, sustaining one word per cycle.
// Ports       : rdclk         - read-domain clock
//               in_resetn     - synchronous active-low reset
//               in_fifo_empty - empty flag from the read pointer handler
//               in_ram_rdata  - RAM read data, valid cycle after a read
//               out_rd_req    - read request to the handler
//               in_ready      - consumer ready
//               out_valid     - buffer head holds a word
//               out_data      - buffer head word
//               out_count     - words currently held in the buffer
// Revision    : 1.0 - initial release
// ============================================================================
module rd_fwft_stage
    import rd_fwft_stage_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEFAULT,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 2
) (
    input  logic             rdclk,
    input  logic             in_resetn,
    input  logic             in_fifo_empty,
    input  logic [DSIZE-1:0] in_ram_rdata,
    output logic             out_rd_req,
    input  logic             in_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int             PTR_W       = ptr_width(BUF_DEPTH);
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W:0]   credits_used;
    logic             rd_fire;
    logic             pop;

    // A word in flight already owns a buffer slot, so it counts against the
    // credit limit. Only registered state and the empty flag feed the request.
    assign credits_used = {1'b0, occ_q} + {{CNT_W{1'b0}}, inflight_q};
    assign out_rd_req   = !in_fifo_empty && (credits_used < DEPTH_LIMIT);
    assign rd_fire      = out_rd_req && !in_fifo_empty;

    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && in_ready;
    assign out_count = occ_q;

    always_comb begin
        inflight_d = rd_fire;
        occ_d      = occ_q + CNT_W'(inflight_q) - CNT_W'(pop);
    end

    always_ff @(posedge rdclk) begin
        if (!in_resetn) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    fwft_buf_mem #(
        .DSIZE (DSIZE),
        .DEPTH (BUF_DEPTH),
        .PTR_W (PTR_W)
    ) u_buf_mem (
        .clk       (rdclk),
        .resetn    (in_resetn),
        .i_wr_en   (inflight_q),
        .i_wr_data (in_ram_rdata),
        .i_pop     (pop),
        .o_rd_data (out_data)
    );

endmodule : rd_fwft_stage
`default_nettype wire
